// File: rtl/fetch_controller.sv
// IF-stage sequencer for a variable-latency instruction memory: PC freeze,
// IF/ID valid/flush, skid-register control, fetch timeout and stall counter.
module fetch_controller #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        Branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        pc_freeze,
    output logic        if_valid,
    output logic        flush,
    output logic        hold_load,
    output logic        use_hold,
    output logic        fetch_error,
    output logic [15:0] stall_cycles
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, DISCARD, ERROR} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [15:0]   stall_q, stall_d;
    logic          waiting;

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        pc_freeze = 1'b1;
        if_valid  = 1'b0;
        flush     = 1'b0;
        hold_load = 1'b0;
        use_hold  = 1'b0;
        waiting   = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (Branch_taken) begin
                    flush     = 1'b1;
                    pc_freeze = 1'b0;
                    state_d   = mem_ready ? FETCH : DISCARD;
                end else if (mem_ready) begin
                    if (!hazard) begin
                        if_valid  = 1'b1;
                        pc_freeze = 1'b0;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            HOLD: begin
                if (Branch_taken) begin
                    // Skid content is simply abandoned; next fetch is the target.
                    flush     = 1'b1;
                    pc_freeze = 1'b0;
                    state_d   = FETCH;
                end else if (!hazard) begin
                    if_valid  = 1'b1;
                    use_hold  = 1'b1;
                    pc_freeze = 1'b0;
                    state_d   = FETCH;
                end
            end
            DISCARD: begin
                mem_req = 1'b1;
                if (Branch_taken) begin
                    flush     = 1'b1;
                    pc_freeze = 1'b0;
                    state_d   = mem_ready ? FETCH : DISCARD;
                end else if (mem_ready) begin
                    state_d = FETCH;
                end else begin
                    waiting = 1'b1;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
        // The cycle that brings the wait count to MAX_WAIT is the last one tolerated.
        if (waiting && wait_q == WAIT_LAST) state_d = ERROR;
    end

    always_comb begin
        wait_d  = '0;
        stall_d = stall_q;
        if (waiting && state_d == state_q) wait_d = wait_q + 1'b1;
        if (pc_freeze && (state_q == FETCH || state_q == HOLD || state_q == DISCARD) &&
            stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign fetch_error  = (state_q == ERROR);
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed-vector bench for fetch_controller with hand-computed expectations.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0, Branch_taken = 1'b0, mem_ready = 1'b0;
    logic        mem_req, pc_freeze, if_valid, flush, hold_load, use_hold, fetch_error;
    logic [15:0] stall_cycles;
    int          n_vec = 0;
    int          n_bad = 0;

    // {mem_req, pc_freeze, if_valid, flush, hold_load, use_hold, fetch_error}
    localparam logic [6:0] O_RST   = 7'b0100000;
    localparam logic [6:0] O_WAIT  = 7'b1100000;
    localparam logic [6:0] O_ISSUE = 7'b1010000;
    localparam logic [6:0] O_HLOAD = 7'b1100100;
    localparam logic [6:0] O_HOLD  = 7'b0100000;
    localparam logic [6:0] O_HISS  = 7'b0010010;
    localparam logic [6:0] O_FLUSH = 7'b1001000;
    localparam logic [6:0] O_HFLSH = 7'b0001000;
    localparam logic [6:0] O_ERR   = 7'b0100001;

    fetch_controller #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .hazard(hazard), .Branch_taken(Branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_freeze(pc_freeze),
        .if_valid(if_valid), .flush(flush), .hold_load(hold_load),
        .use_hold(use_hold), .fetch_error(fetch_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, then check outputs and counter mid-cycle.
    task automatic step(input string tag, input logic hz, input logic br, input logic mr,
                        input logic [6:0] exp_o, input logic [15:0] exp_s);
        @(negedge clk);
        rst = 1'b0; hazard = hz; Branch_taken = br; mem_ready = mr;
        #1;
        chk(tag, {9'd0, mem_req, pc_freeze, if_valid, flush, hold_load, use_hold, fetch_error},
            {9'd0, exp_o});
        chk({tag, "_stall"}, stall_cycles, exp_s);
    endtask

    task automatic do_rst(input string tag);
        @(negedge clk);
        rst = 1'b1; hazard = 1'b0; Branch_taken = 1'b0; mem_ready = 1'b0;
        #1;
        chk(tag, {9'd0, mem_req, pc_freeze, if_valid, flush, hold_load, use_hold, fetch_error},
            {9'd0, O_RST});
        chk({tag, "_stall"}, stall_cycles, 16'd0);
        @(negedge clk);
    endtask

    initial begin
        do_rst("por");
        // Release, one IDLE cycle, then a single wait before a zero-wait stream.
        step("idle", 0, 0, 0, O_RST, 0);
        step("first_wait", 0, 0, 0, O_WAIT, 0);
        for (int i = 0; i < 8; i++) step("stream", 0, 0, 1, O_ISSUE, 1);
        // mem_ready every third cycle: two stalls per instruction.
        for (int k = 1; k <= 3; k++) begin
            step("p3_wait", 0, 0, 0, O_WAIT, 16'(1 + 2*k - 2));
            step("p3_wait", 0, 0, 0, O_WAIT, 16'(1 + 2*k - 1));
            step("p3_issue", 0, 0, 1, O_ISSUE, 16'(1 + 2*k));
        end
        // Response arrives with a hazard: skid load, 4 held cycles, issue from skid.
        step("hz_load", 1, 0, 1, O_HLOAD, 7);
        for (int i = 0; i < 4; i++) step("hz_hold", 1, 0, 0, O_HOLD, 16'(8 + i));
        step("hz_issue", 0, 0, 0, O_HISS, 12);
        // Branch with request outstanding: flush, drop late response, refetch.
        step("br_wait", 0, 0, 0, O_WAIT, 12);
        step("br_flush", 0, 1, 0, O_FLUSH, 13);
        step("disc_wait", 0, 0, 0, O_WAIT, 13);
        step("disc_drop", 0, 0, 1, O_WAIT, 14);
        step("tgt_wait", 0, 0, 0, O_WAIT, 15);
        step("tgt_issue", 0, 0, 1, O_ISSUE, 16);
        // Branch coinciding with a response: dropped, no DISCARD.
        step("br_rdy", 0, 1, 1, O_FLUSH, 16);
        step("br_rdy_next", 0, 0, 1, O_ISSUE, 16);
        // Branch while holding abandons the skid.
        step("hb_load", 1, 0, 1, O_HLOAD, 16);
        step("hb_flush", 1, 1, 0, O_HFLSH, 17);
        step("hb_next", 0, 0, 1, O_ISSUE, 17);
        // Reset from HOLD; fresh fetch afterwards, never from the skid.
        step("rh_load", 1, 0, 1, O_HLOAD, 17);
        step("rh_hold", 1, 0, 0, O_HOLD, 18);
        do_rst("rst_hold");
        step("rh_idle", 0, 0, 1, O_RST, 0);
        step("rh_wait", 0, 0, 0, O_WAIT, 0);
        step("rh_issue", 0, 0, 1, O_ISSUE, 1);
        // Reset from DISCARD.
        step("rd_flush", 0, 1, 0, O_FLUSH, 1);
        step("rd_disc", 0, 0, 0, O_WAIT, 1);
        do_rst("rst_disc");
        // Timeout after 15 waiting cycles; ERROR is absorbing until reset.
        step("to_idle", 0, 0, 0, O_RST, 0);
        for (int i = 0; i < 15; i++) step("to_wait", 0, 0, 0, O_WAIT, 16'(i));
        step("err", 0, 0, 0, O_ERR, 15);
        step("err_rdy", 0, 0, 1, O_ERR, 15);
        step("err_all", 1, 1, 1, O_ERR, 15);
        do_rst("rst_err");
        step("post_err_idle", 0, 0, 1, O_RST, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
